fifo_frame_buf: RTL and testbench



---
 rtl/fifo_frame_pkg.sv | 15 +
 rtl/fifo_frame_ctrl.sv | 80 ++++++++
 rtl/fifo_frame_buf.sv | 123 ++++++++++++
 tb/tb_fifo_frame_buf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_pkg.sv
// Shared types and helpers for the audio frame FIFO feeding the FFT stage.
package fifo_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_STREAM = 2'd2
    } frame_state_t;

    // Pointer width needed to address a power-of-two storage of the given depth.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_frame_ctrl.sv
// Frame handshake FSM: announces a buffered frame, accepts the FFT start request
// and counts the reads of the frame being streamed out.
module fifo_frame_ctrl
    import fifo_frame_pkg::*;
#(
    parameter int unsigned CW        = 8,
    parameter int unsigned FRAME_LEN = 128
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [CW-1:0] count,
    input  logic          rd_acc,
    input  logic          start_fft_in,
    output logic          frame_ready,
    output logic          start_fft,
    output logic          frame_done
);

    frame_state_t  state;
    frame_state_t  state_d;
    logic [CW-1:0] frm_cnt;
    logic [CW-1:0] frm_cnt_d;
    logic          frame_ready_d;
    logic          start_fft_d;
    logic          frame_done_d;

    // State, frame-read counter and the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            frm_cnt     <= '0;
            frame_ready <= 1'b0;
            start_fft   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_d;
            frm_cnt     <= frm_cnt_d;
            frame_ready <= frame_ready_d;
            start_fft   <= start_fft_d;
            frame_done  <= frame_done_d;
        end
    end

    always_comb begin
        state_d   = state;
        frm_cnt_d = frm_cnt;
        case (state)
            ST_IDLE: begin
                if (count >= CW'(FRAME_LEN)) state_d = ST_READY;
            end
            ST_READY: begin
                // Draining reads can take the buffer below a full frame again.
                if (count < CW'(FRAME_LEN)) begin
                    state_d = ST_IDLE;
                end else if (start_fft_in) begin
                    state_d   = ST_STREAM;
                    frm_cnt_d = '0;
                end
            end
            ST_STREAM: begin
                if (rd_acc) begin
                    if (frm_cnt == CW'(FRAME_LEN - 1)) begin
                        state_d   = ST_IDLE;
                        frm_cnt_d = '0;
                    end else begin
                        frm_cnt_d = frm_cnt + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_ready_d = (state_d == ST_READY);
        start_fft_d   = (state == ST_READY) && (state_d == ST_STREAM);
        frame_done_d  = (state == ST_STREAM) && (state_d == ST_IDLE);
    end

endmodule

// File: rtl/fifo_frame_buf.sv
// Circular sample FIFO with FFT frame handshake and sticky overflow/underflow error.
// Optional almost-full/almost-empty flags enabled by FIFO_FRAME_ALMOST_FLAGS_EN.
module fifo_frame_buf
    import fifo_frame_pkg::*;
#(
    parameter int unsigned DWIDTH        = 32,
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned FRAME_LEN     = 128,
    parameter int unsigned ALMOST_MARGIN = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   wr_ce,
    input  logic [DWIDTH-1:0]      data_in,
    input  logic                   rd_ce,
    output logic [DWIDTH-1:0]      data_out,
    input  logic                   start_fft_in,
    output logic                   start_fft,
    output logic                   frame_ready,
    output logic                   frame_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    input  logic                   err_clr,
    output logic                   error,
    output logic                   almost_full,
    output logic                   almost_empty
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr_d;
    logic [AW-1:0]     rd_ptr_d;
    logic [CW-1:0]     cnt_d;
    logic [DWIDTH-1:0] dout_d;
    logic              wr_acc;
    logic              rd_acc;
    logic              fault;

    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign wr_acc = wr_ce && (!full || rd_ce);
    assign rd_acc = rd_ce && !empty;
    assign fault  = (wr_ce && full && !rd_ce) || (rd_ce && empty);

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_d = rd_acc ? rd_ptr + AW'(1) : rd_ptr;
        cnt_d    = count;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = count + CW'(1);
            2'b01:   cnt_d = count - CW'(1);
            default: cnt_d = count;
        endcase
        // Next head comes straight from data_in when the write lands on it.
        if (cnt_d == '0) begin
            dout_d = '0;
        end else if (wr_acc && (wr_ptr == rd_ptr_d)) begin
            dout_d = data_in;
        end else begin
            dout_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            data_out <= '0;
            error    <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            count    <= cnt_d;
            full     <= (cnt_d == CW'(DEPTH));
            empty    <= (cnt_d == '0);
            data_out <= dout_d;
            error    <= fault || (error && !err_clr);
        end
    end

`ifdef FIFO_FRAME_ALMOST_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (cnt_d >= CW'(DEPTH - ALMOST_MARGIN));
            almost_empty <= (cnt_d <= CW'(ALMOST_MARGIN));
        end
    end
`else
    logic unused_margin;
    assign unused_margin = ^(32'(ALMOST_MARGIN));
    assign almost_full   = 1'b0;
    assign almost_empty  = 1'b0;
`endif

    fifo_frame_ctrl #(
        .CW        (CW),
        .FRAME_LEN (FRAME_LEN)
    ) u_ctrl (
        .clk          (clk),
        .n_rst        (n_rst),
        .count        (count),
        .rd_acc       (rd_acc),
        .start_fft_in (start_fft_in),
        .frame_ready  (frame_ready),
        .start_fft    (start_fft),
        .frame_done   (frame_done)
    );

endmodule

// File: tb/tb_fifo_frame_buf.sv
// Scoreboard bench for fifo_frame_buf (DEPTH=8, FRAME_LEN=4, ALMOST_MARGIN=2).
// Almost-flag expectations follow FIFO_FRAME_ALMOST_FLAGS_EN.
module tb_fifo_frame_buf;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          wr_ce = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_ce = 1'b0;
    logic [DW-1:0] data_out;
    logic          start_fft_in = 1'b0;
    logic          start_fft;
    logic          frame_ready;
    logic          frame_done;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          err_clr = 1'b0;
    logic          error;
    logic          almost_full;
    logic          almost_empty;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_done   = 0;

    logic [DW-1:0] sb[$];
    logic          m_err = 1'b0;

    fifo_frame_buf #(
        .DWIDTH(DW), .DEPTH(DEPTH), .FRAME_LEN(4), .ALMOST_MARGIN(2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .wr_ce(wr_ce), .data_in(data_in), .rd_ce(rd_ce),
        .data_out(data_out), .start_fft_in(start_fft_in), .start_fft(start_fft),
        .frame_ready(frame_ready), .frame_done(frame_done), .count(count),
        .full(full), .empty(empty), .err_clr(err_clr), .error(error),
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_fft)  n_start++;
        if (frame_done) n_done++;
    end

    // One clock of stimulus; updates the reference model and returns the popped expectation.
    task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rd,
                         input logic st, input logic clr,
                         output logic popped, output logic [DW-1:0] exp_d,
                         output logic [DW-1:0] obs_d);
        logic m_wr, m_rd, flt;
        wr_ce = wr; data_in = d; rd_ce = rd; start_fft_in = st; err_clr = clr;
        obs_d  = data_out;
        popped = 1'b0;
        exp_d  = '0;
        m_wr = wr && ((sb.size() < DEPTH) || rd);
        m_rd = rd && (sb.size() > 0);
        flt  = (wr && (sb.size() == DEPTH) && !rd) || (rd && (sb.size() == 0));
        if (m_rd) begin exp_d = sb.pop_front(); popped = 1'b1; end
        if (m_wr) sb.push_back(d);
        m_err = flt || (m_err && !clr);
        @(posedge clk); #1;
        wr_ce = 1'b0; rd_ce = 1'b0; start_fft_in = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        sb.delete(); m_err = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (frame_ready !== 1'b0) begin n_errors++; $display("FAIL reset_frame_ready: got %b expected 0", frame_ready); end
        n_checks++; if (data_out !== 32'h0) begin n_errors++; $display("FAIL reset_data_out: got %0h expected 0", data_out); end
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b expected 0", error); end
        n_checks++; if ((start_fft !== 1'b0) || (frame_done !== 1'b0)) begin n_errors++; $display("FAIL reset_pulses: got %b%b expected 00", start_fft, frame_done); end
    endtask

    task automatic test_fill_frame();
        logic p; logic [DW-1:0] e, o;
        for (int i = 1; i <= 4; i++) drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, p, e, o);
        n_checks++; if (count !== 4'd4) begin n_errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        n_checks++; if (frame_ready !== 1'b0) begin n_errors++; $display("FAIL fill_ready_early: got %b expected 0", frame_ready); end
        n_checks++; if (data_out !== 32'h1) begin n_errors++; $display("FAIL fill_head: got %0h expected 1", data_out); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, p, e, o);
        n_checks++; if (frame_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready: got %b expected 1", frame_ready); end
    endtask

    task automatic test_frame_stream();
        logic p; logic [DW-1:0] e, o;
        int s0, d0;
        s0 = n_start; d0 = n_done;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, p, e, o);
        n_checks++; if (start_fft !== 1'b1) begin n_errors++; $display("FAIL stream_start_pulse: got %b expected 1", start_fft); end
        n_checks++; if (frame_ready !== 1'b0) begin n_errors++; $display("FAIL stream_ready_drop: got %b expected 0", frame_ready); end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, p, e, o);
            n_checks++; if (!p || o !== e || o !== DW'(i)) begin n_errors++; $display("FAIL stream_data%0d: got %0h expected %0h", i, o, i); end
            if (i < 4) begin
                n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL stream_done_early%0d: got %b expected 0", i, frame_done); end
            end
        end
        n_checks++; if (frame_done !== 1'b1) begin n_errors++; $display("FAIL stream_done: got %b expected 1", frame_done); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL stream_empty: got %b expected 1", empty); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, p, e, o);
        n_checks++; if ((n_start - s0) != 1 || (n_done - d0) != 1) begin n_errors++; $display("FAIL stream_pulse_count: got %0d/%0d expected 1/1", n_start - s0, n_done - d0); end
    endtask

    task automatic test_overflow();
        logic p; logic [DW-1:0] e, o;
        for (int i = 0; i < 8; i++) drive(1'b1, DW'(32'h10 + i), 1'b0, 1'b0, 1'b0, p, e, o);
        n_checks++; if (full !== 1'b1 || count !== 4'd8) begin n_errors++; $display("FAIL ovf_full: got full=%b count=%0d expected 1/8", full, count); end
        repeat (2) drive(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0, p, e, o);
        n_checks++; if (count !== 4'd8) begin n_errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL ovf_error: got %b expected 1", error); end
        drive(1'b1, 32'hEF, 1'b0, 1'b0, 1'b1, p, e, o);
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL ovf_clr_vs_fault: got %b expected 1", error); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, p, e, o);
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL ovf_clr: got %b expected 0", error); end
    endtask

    task automatic test_full_rdwr();
        logic p; logic [DW-1:0] e, o;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'h20 + i), 1'b1, 1'b0, 1'b0, p, e, o);
            n_checks++; if (!p || o !== e) begin n_errors++; $display("FAIL full_rdwr_data%0d: got %0h expected %0h", i, o, e); end
        end
        n_checks++; if (count !== 4'd8 || full !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL full_rdwr_state: got count=%0d full=%b err=%b expected 8/1/0", count, full, error); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, p, e, o);
            n_checks++; if (!p || o !== e) begin n_errors++; $display("FAIL drain_data%0d: got %0h expected %0h", i, o, e); end
        end
        n_checks++; if (empty !== 1'b1 || data_out !== 32'h0) begin n_errors++; $display("FAIL drain_empty: got empty=%b dout=%0h expected 1/0", empty, data_out); end
    endtask

    task automatic test_underflow();
        logic p; logic [DW-1:0] e, o;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, p, e, o);
        n_checks++; if (error !== 1'b1 || count !== 4'd0) begin n_errors++; $display("FAIL udf_error: got err=%b count=%0d expected 1/0", error, count); end
        drive(1'b1, 32'hA, 1'b1, 1'b0, 1'b0, p, e, o);
        n_checks++; if (count !== 4'd1 || data_out !== 32'hA) begin n_errors++; $display("FAIL udf_wr: got count=%0d dout=%0h expected 1/a", count, data_out); end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, p, e, o);
        n_checks++; if (!p || o !== 32'hA || count !== 4'd0 || error !== 1'b0) begin n_errors++; $display("FAIL udf_pop: got dout=%0h count=%0d err=%b expected a/0/0", o, count, error); end
    endtask

    task automatic test_reset_mid_stream();
        logic p; logic [DW-1:0] e, o;
        int d0;
        for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'h30 + i), 1'b0, 1'b0, 1'b0, p, e, o);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, p, e, o);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, p, e, o);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, p, e, o);
            n_checks++; if (!p || o !== e) begin n_errors++; $display("FAIL mid_data%0d: got %0h expected %0h", i, o, e); end
        end
        d0 = n_done;
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        sb.delete(); m_err = 1'b0;
        n_checks++; if (count !== 4'd0 || frame_ready !== 1'b0 || empty !== 1'b1) begin n_errors++; $display("FAIL mid_reset: got count=%0d ready=%b empty=%b expected 0/0/1", count, frame_ready, empty); end
        for (int i = 0; i < 2; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b1, p, e, o);
        repeat (4) drive(1'b0, '0, 1'b0, 1'b0, 1'b1, p, e, o);
        n_checks++; if (n_done != d0) begin n_errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", n_done - d0); end
    endtask

    task automatic test_almost();
        logic p; logic [DW-1:0] e, o;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, DW'(32'h40 + i), 1'b0, 1'b0, 1'b0, p, e, o);
`ifdef FIFO_FRAME_ALMOST_FLAGS_EN
            if (i == 2) begin n_checks++; if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL almost_empty_2: got %b expected 1", almost_empty); end end
            if (i == 3) begin n_checks++; if (almost_empty !== 1'b0) begin n_errors++; $display("FAIL almost_empty_3: got %b expected 0", almost_empty); end end
            if (i == 5) begin n_checks++; if (almost_full !== 1'b0) begin n_errors++; $display("FAIL almost_full_5: got %b expected 0", almost_full); end end
            if (i == 6) begin n_checks++; if (almost_full !== 1'b1) begin n_errors++; $display("FAIL almost_full_6: got %b expected 1", almost_full); end end
`else
            n_checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin n_errors++; $display("FAIL almost_tied%0d: got %b%b expected 00", i, almost_full, almost_empty); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic p; logic [DW-1:0] e, o;
        logic wr, rd, clr;
        for (int i = 0; i < 300; i++) begin
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 7) == 0);
            drive(wr, DW'($urandom), rd, 1'($urandom_range(0, 1)), clr, p, e, o);
            if (p) begin
                n_checks++; if (o !== e) begin n_errors++; $display("FAIL b2b_data%0d: got %0h expected %0h", i, o, e); end
            end
            n_checks++;
            if (count !== 4'(sb.size()) || full !== (sb.size() == DEPTH) || empty !== (sb.size() == 0) || error !== m_err) begin
                n_errors++;
                $display("FAIL b2b_state%0d: got count=%0d full=%b empty=%b err=%b expected %0d/%b/%b/%b",
                         i, count, full, empty, error, sb.size(), sb.size() == DEPTH, sb.size() == 0, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_frame();
        test_frame_stream();
        test_overflow();
        test_full_rdwr();
        test_underflow();
        test_reset_mid_stream();
        test_almost();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
